// File: rtl/spinning_disk.sv
// Seven-segment spinning-disk animator: one outer segment lit, rotating while Start is high.
// Latency: SSeg registered, 1 clk after Start is sampled; no backpressure, Start=0 pauses in place.
module spinning_disk #(
    parameter int STEP_CYCLES = 1,
    parameter bit CW          = 1'b1,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic       Clk,
    input  logic       nReset,
    input  logic       Start,
    output logic [7:0] SSeg
);

    localparam int                 CNT_W   = $clog2(STEP_CYCLES) + 1;
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(STEP_CYCLES - 1);
    localparam logic [7:0]         BLANK   = ACTIVE_LOW ? 8'hFF : 8'h00;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        POS_A = 3'd1,
        POS_B = 3'd2,
        POS_C = 3'd3,
        POS_D = 3'd4,
        POS_E = 3'd5,
        POS_F = 3'd6
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       sseg_q, sseg_d;
    logic [5:0]       lit;

    function automatic state_t next_pos(input state_t s);
        state_t n;
        n = IDLE;
        if (CW) begin
            case (s)
                POS_A:   n = POS_B;
                POS_B:   n = POS_C;
                POS_C:   n = POS_D;
                POS_D:   n = POS_E;
                POS_E:   n = POS_F;
                POS_F:   n = POS_A;
                default: n = IDLE;
            endcase
        end else begin
            case (s)
                POS_A:   n = POS_F;
                POS_F:   n = POS_E;
                POS_E:   n = POS_D;
                POS_D:   n = POS_C;
                POS_C:   n = POS_B;
                POS_B:   n = POS_A;
                default: n = IDLE;
            endcase
        end
        return n;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d = POS_A;
                    cnt_d   = '0;
                end
            end
            POS_A, POS_B, POS_C, POS_D, POS_E, POS_F: begin
                // Start low freezes both position and step count so a resume continues mid-step
                if (Start) begin
                    if (cnt_q == CNT_MAX) begin
                        state_d = next_pos(state_q);
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Decode from the next state so SSeg changes on the same edge as the state register
    always_comb begin
        lit = 6'b000000;
        case (state_d)
            POS_A:   lit = 6'b000001;
            POS_B:   lit = 6'b000010;
            POS_C:   lit = 6'b000100;
            POS_D:   lit = 6'b001000;
            POS_E:   lit = 6'b010000;
            POS_F:   lit = 6'b100000;
            default: lit = 6'b000000;
        endcase
        sseg_d = ACTIVE_LOW ? ~{2'b00, lit} : {2'b00, lit};
    end

    always_ff @(posedge Clk) begin
        if (nReset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sseg_q  <= BLANK;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sseg_q  <= sseg_d;
        end
    end

    assign SSeg = sseg_q;

endmodule

// File: tb/tb_spinning_disk.sv
// Bench for spinning_disk: three parameterisations driven together, checked against a position/count model.
module tb_spinning_disk;

    logic       clk = 1'b0;
    logic       n_reset;
    logic       start;
    logic [7:0] sseg0, sseg1, sseg2;

    always #5 clk = ~clk;

    spinning_disk #(.STEP_CYCLES(1), .CW(1'b1), .ACTIVE_LOW(1'b1)) dut0 (
        .Clk(clk), .nReset(n_reset), .Start(start), .SSeg(sseg0));
    spinning_disk #(.STEP_CYCLES(3), .CW(1'b0), .ACTIVE_LOW(1'b1)) dut1 (
        .Clk(clk), .nReset(n_reset), .Start(start), .SSeg(sseg1));
    spinning_disk #(.STEP_CYCLES(2), .CW(1'b1), .ACTIVE_LOW(1'b0)) dut2 (
        .Clk(clk), .nReset(n_reset), .Start(start), .SSeg(sseg2));

    int checks = 0;
    int errors = 0;

    // Model: pos = -1 blank, 0..5 = segment a..f; cnt = Start-high cycles spent at pos
    int       pos   [3];
    int       cnt   [3];
    const int steps [3] = '{1, 3, 2};
    const bit cw    [3] = '{1'b1, 1'b0, 1'b1};
    const bit al    [3] = '{1'b1, 1'b1, 1'b0};

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] seg_of(input int p, input bit active_low);
        logic [7:0] v;
        v = (p < 0) ? 8'h00 : 8'(1 << p);
        return active_low ? ~v : v;
    endfunction

    task automatic model_step(input logic rst, input logic st);
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                pos[i] = -1;
                cnt[i] = 0;
            end else if (pos[i] < 0) begin
                if (st) begin
                    pos[i] = 0;
                    cnt[i] = 0;
                end
            end else if (st) begin
                if (cnt[i] + 1 >= steps[i]) begin
                    pos[i] = cw[i] ? (pos[i] + 1) % 6 : (pos[i] + 5) % 6;
                    cnt[i] = 0;
                end else begin
                    cnt[i]++;
                end
            end
        end
    endtask

    task automatic cycle(input logic rst, input logic st, input string tag);
        @(negedge clk);
        n_reset = rst;
        start   = st;
        @(posedge clk);
        model_step(rst, st);
        #1;
        check({tag, "_d0"}, sseg0, seg_of(pos[0], al[0]));
        check({tag, "_d1"}, sseg1, seg_of(pos[1], al[1]));
        check({tag, "_d2"}, sseg2, seg_of(pos[2], al[2]));
    endtask

    // Directed step with an additional fixed expectation for the default-parameter instance
    task automatic cycle_k(input logic rst, input logic st, input logic [7:0] exp0, input string tag);
        cycle(rst, st, tag);
        check({tag, "_k0"}, sseg0, exp0);
    endtask

    initial begin
        n_reset = 1'b1;
        start   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pos[i] = -1;
            cnt[i] = 0;
        end

        cycle_k(1'b1, 1'b0, 8'hFF, "rst");
        cycle_k(1'b0, 1'b0, 8'hFF, "idle");
        cycle_k(1'b0, 1'b0, 8'hFF, "idle");
        cycle_k(1'b0, 1'b1, 8'hFE, "segA");
        cycle_k(1'b0, 1'b1, 8'hFD, "segB");
        cycle_k(1'b0, 1'b1, 8'hFB, "segC");
        cycle_k(1'b0, 1'b0, 8'hFB, "pause");
        cycle_k(1'b0, 1'b0, 8'hFB, "pause");
        cycle_k(1'b0, 1'b1, 8'hF7, "segD");
        cycle_k(1'b0, 1'b1, 8'hEF, "segE");
        cycle_k(1'b0, 1'b1, 8'hDF, "segF");
        cycle_k(1'b0, 1'b1, 8'hFE, "wrap");
        cycle_k(1'b0, 1'b1, 8'hFD, "segB2");
        cycle_k(1'b1, 1'b1, 8'hFF, "midrst");
        cycle_k(1'b0, 1'b1, 8'hFE, "rstart");

        // Slow CCW instance: A held 3 Start-high cycles, pause mid-step, then F and E
        cycle(1'b1, 1'b0, "ccw_rst");
        cycle(1'b0, 1'b1, "ccw_a0");
        check("ccw_a0_lit", sseg1, 8'hFE);
        cycle(1'b0, 1'b1, "ccw_a1");
        cycle(1'b0, 1'b0, "ccw_hold");
        cycle(1'b0, 1'b0, "ccw_hold");
        check("ccw_hold_lit", sseg1, 8'hFE);
        cycle(1'b0, 1'b1, "ccw_a2");
        check("ccw_a2_lit", sseg1, 8'hFE);
        cycle(1'b0, 1'b1, "ccw_f");
        check("ccw_f_lit", sseg1, 8'hDF);
        cycle(1'b0, 1'b1, "ccw_f1");
        cycle(1'b0, 1'b1, "ccw_f2");
        cycle(1'b0, 1'b1, "ccw_e");
        check("ccw_e_lit", sseg1, 8'hEF);

        for (int n = 0; n < 1500; n++) begin
            cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
